// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and default-slave FSM state type used by the interconnect.
package ahb_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  localparam logic [2:0] HsizeByte = 3'b000;
  localparam logic [2:0] HsizeHalf = 3'b001;
  localparam logic [2:0] HsizeWord = 3'b010;

  localparam logic [2:0] HburstSingle = 3'b000;
  localparam logic [2:0] HburstIncr   = 3'b001;

  typedef enum logic [1:0] {
    DsIdle = 2'b00,
    DsErr1 = 2'b01,
    DsErr2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with the two-cycle AHB ERROR response.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic hready,
  output logic hresp,
  output logic err1
);

  ds_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DsIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hready  = 1'b1;
    hresp   = HrespOkay;
    unique case (state_q)
      DsIdle: begin
        if (start) state_d = DsErr1;
      end
      DsErr1: begin
        hready  = 1'b0;
        hresp   = HrespError;
        state_d = DsErr2;
      end
      DsErr2: begin
        hresp   = HrespError;
        // A new unmapped transfer accepted here chains straight into another error.
        state_d = start ? DsErr1 : DsIdle;
      end
      default: state_d = DsIdle;
    endcase
  end

  assign err1 = (state_q == DsErr1);

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: address decoder, data-phase response mux,
// built-in default slave and sticky first-error capture.
module ahb_lite_interconnect
  import ahb_pkg::*;
#(
  parameter int unsigned           NUM_S     = 3,
  parameter int unsigned           AW        = 32,
  parameter int unsigned           DW        = 32,
  parameter logic [NUM_S*AW-1:0]   BASE_ADDR = '0,
  parameter logic [NUM_S*AW-1:0]   ADDR_MASK = '0
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [AW-1:0]                  M_HADDR,
  input  logic [1:0]                     M_HTRANS,
  input  logic                           M_HWRITE,
  input  logic [2:0]                     M_HSIZE,
  input  logic [2:0]                     M_HBURST,
  input  logic [3:0]                     M_HPROT,
  input  logic                           M_HMASTLOCK,
  input  logic [DW-1:0]                  M_HWDATA,
  output logic [NUM_S-1:0]               HSEL,
  output logic [AW-1:0]                  HADDR,
  output logic [1:0]                     HTRANS,
  output logic                           HWRITE,
  output logic [2:0]                     HSIZE,
  output logic [2:0]                     HBURST,
  output logic [3:0]                     HPROT,
  output logic                           HMASTLOCK,
  output logic [DW-1:0]                  HWDATA,
  input  logic [NUM_S*DW-1:0]            S_HRDATA,
  input  logic [NUM_S-1:0]               S_HREADYOUT,
  input  logic [NUM_S-1:0]               S_HRESP,
  output logic [DW-1:0]                  HRDATA,
  output logic                           HREADY,
  output logic                           HRESP,
  input  logic                           ERR_CLR,
  output logic                           ERR_VALID,
  output logic [AW-1:0]                  ERR_ADDR,
  output logic [$clog2(NUM_S+1)-1:0]     ERR_SRC
);

  localparam int unsigned SW = $clog2(NUM_S + 1);

  assign HADDR     = M_HADDR;
  assign HTRANS    = M_HTRANS;
  assign HWRITE    = M_HWRITE;
  assign HSIZE     = M_HSIZE;
  assign HBURST    = M_HBURST;
  assign HPROT     = M_HPROT;
  assign HMASTLOCK = M_HMASTLOCK;
  assign HWDATA    = M_HWDATA;

  logic [NUM_S-1:0] match;
  logic [DW-1:0]    rdata_arr [NUM_S];
  logic             hit;
  logic [SW-1:0]    win;

  for (genvar g = 0; g < NUM_S; g++) begin : g_dec
    assign match[g] = (M_HADDR & ADDR_MASK[g*AW +: AW]) ==
                      (BASE_ADDR[g*AW +: AW] & ADDR_MASK[g*AW +: AW]);
    assign rdata_arr[g] = S_HRDATA[g*DW +: DW];
    assign HSEL[g]      = hit && (win == SW'(g));
  end

  // Scan downwards so the lowest matching index wins on overlap.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = int'(NUM_S) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        win = SW'(i);
      end
    end
  end

  logic          dp_slv_q, dp_def_q;
  logic [SW-1:0] dp_idx_q;
  logic [AW-1:0] dp_addr_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_slv_q  <= 1'b0;
      dp_def_q  <= 1'b0;
      dp_idx_q  <= '0;
      dp_addr_q <= '0;
    end else if (HREADY) begin
      dp_slv_q  <= hit;
      dp_def_q  <= !hit && M_HTRANS[1];
      dp_idx_q  <= win;
      dp_addr_q <= M_HADDR;
    end
  end

  logic ds_hready, ds_hresp, ds_err1, ds_start;

  assign ds_start = HREADY && !hit && M_HTRANS[1];

  ahb_default_slave u_default_slave (
    .clk    (HCLK),
    .rst    (HRESET),
    .start  (ds_start),
    .hready (ds_hready),
    .hresp  (ds_hresp),
    .err1   (ds_err1)
  );

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HrespOkay;
    HRDATA = '0;
    if (dp_def_q) begin
      HREADY = ds_hready;
      HRESP  = ds_hresp;
    end else if (dp_slv_q) begin
      for (int i = 0; i < int'(NUM_S); i++) begin
        if (dp_idx_q == SW'(i)) begin
          HREADY = S_HREADYOUT[i];
          HRESP  = S_HRESP[i];
          HRDATA = rdata_arr[i];
        end
      end
    end
  end

  // Both events mark the first cycle of a two-cycle ERROR response.
  logic          slv_err, err_event;
  logic [SW-1:0] err_src;

  assign slv_err   = dp_slv_q && HRESP && !HREADY;
  assign err_event = slv_err || ds_err1;
  assign err_src   = ds_err1 ? SW'(NUM_S) : dp_idx_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= '0;
      ERR_SRC   <= '0;
    end else if (err_event && (!ERR_VALID || ERR_CLR)) begin
      ERR_VALID <= 1'b1;
      ERR_ADDR  <= dp_addr_q;
      ERR_SRC   <= err_src;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed self-checking bench for ahb_lite_interconnect with three slaves on 256 MB windows.
module tb_ahb_lite_interconnect;
  import ahb_pkg::*;

  localparam int unsigned NUM_S = 3;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [AW-1:0]     M_HADDR;
  logic [1:0]        M_HTRANS;
  logic              M_HWRITE;
  logic [2:0]        M_HSIZE;
  logic [2:0]        M_HBURST;
  logic [3:0]        M_HPROT;
  logic              M_HMASTLOCK;
  logic [DW-1:0]     M_HWDATA;
  logic [NUM_S-1:0]  HSEL;
  logic [AW-1:0]     HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic [DW-1:0]     HWDATA;
  logic [NUM_S*DW-1:0] S_HRDATA;
  logic [NUM_S-1:0]  S_HREADYOUT;
  logic [NUM_S-1:0]  S_HRESP;
  logic [DW-1:0]     HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic              ERR_CLR;
  logic              ERR_VALID;
  logic [AW-1:0]     ERR_ADDR;
  logic [1:0]        ERR_SRC;

  logic [DW-1:0] rd0, rd1, rd2;
  assign S_HRDATA = {rd2, rd1, rd0};

  int tests  = 0;
  int failed = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_interconnect #(
    .NUM_S     (NUM_S),
    .AW        (AW),
    .DW        (DW),
    .BASE_ADDR ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .ADDR_MASK ({32'hF000_0000, 32'hF000_0000, 32'hF000_0000})
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .M_HADDR     (M_HADDR),
    .M_HTRANS    (M_HTRANS),
    .M_HWRITE    (M_HWRITE),
    .M_HSIZE     (M_HSIZE),
    .M_HBURST    (M_HBURST),
    .M_HPROT     (M_HPROT),
    .M_HMASTLOCK (M_HMASTLOCK),
    .M_HWDATA    (M_HWDATA),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HMASTLOCK   (HMASTLOCK),
    .HWDATA      (HWDATA),
    .S_HRDATA    (S_HRDATA),
    .S_HREADYOUT (S_HREADYOUT),
    .S_HRESP     (S_HRESP),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .ERR_CLR     (ERR_CLR),
    .ERR_VALID   (ERR_VALID),
    .ERR_ADDR    (ERR_ADDR),
    .ERR_SRC     (ERR_SRC)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; checks run 1 unit later.
  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic bus(input logic [1:0] trans, input logic [AW-1:0] addr, input logic wr);
    M_HTRANS = trans;
    M_HADDR  = addr;
    M_HWRITE = wr;
  endtask

  initial begin
    HRESET      = 1'b1;
    ERR_CLR     = 1'b0;
    M_HSIZE     = HsizeWord;
    M_HBURST    = HburstSingle;
    M_HPROT     = 4'h3;
    M_HMASTLOCK = 1'b0;
    M_HWDATA    = 32'hDEAD_BEEF;
    rd0 = 32'hA0A0_0000;
    rd1 = 32'hB1B1_1111;
    rd2 = 32'hC2C2_2222;
    S_HREADYOUT = 3'b111;
    S_HRESP     = 3'b000;
    bus(HtransIdle, 32'h0, 1'b0);

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_hready", 64'(HREADY), 64'd1);
    chk("rst_hresp", 64'(HRESP), 64'd0);
    chk("rst_hrdata", 64'(HRDATA), 64'd0);
    chk("rst_err_valid", 64'(ERR_VALID), 64'd0);
    chk("rst_err_addr", 64'(ERR_ADDR), 64'd0);
    chk("rst_err_src", 64'(ERR_SRC), 64'd0);
    HRESET = 1'b0;

    // Mapped read to slave 1 with two wait states
    tick();
    bus(HtransNonseq, 32'h1000_0040, 1'b0);
    M_HBURST = HburstIncr;
    #1;
    chk("s1_hsel", 64'(HSEL), 64'b010);
    chk("bc_haddr", 64'(HADDR), 64'h1000_0040);
    chk("bc_htrans", 64'(HTRANS), 64'(HtransNonseq));
    chk("bc_hburst", 64'(HBURST), 64'(HburstIncr));
    chk("bc_hwdata", 64'(HWDATA), 64'hDEAD_BEEF);
    tick();
    bus(HtransIdle, 32'h8000_0000, 1'b0);
    S_HREADYOUT[1] = 1'b0;
    #1;
    chk("s1_wait1_hready", 64'(HREADY), 64'd0);
    chk("s1_hrdata", 64'(HRDATA), 64'hB1B1_1111);
    chk("idle_unmapped_hsel", 64'(HSEL), 64'b000);
    tick();
    #1;
    chk("s1_wait2_hready", 64'(HREADY), 64'd0);
    tick();
    S_HREADYOUT[1] = 1'b1;
    #1;
    chk("s1_done_hready", 64'(HREADY), 64'd1);
    chk("s1_done_hrdata", 64'(HRDATA), 64'hB1B1_1111);
    chk("s1_done_hresp", 64'(HRESP), 64'd0);

    // Unmapped IDLE: OKAY with no wait
    tick();
    #1;
    chk("uidle_hready", 64'(HREADY), 64'd1);
    chk("uidle_hresp", 64'(HRESP), 64'd0);
    chk("uidle_hrdata", 64'(HRDATA), 64'd0);
    chk("uidle_err_valid", 64'(ERR_VALID), 64'd0);

    // Unmapped NONSEQ write; master wobbles HTRANS during ERR1
    bus(HtransNonseq, 32'h8000_0000, 1'b1);
    #1;
    chk("unm_hsel", 64'(HSEL), 64'b000);
    tick();
    bus(HtransNonseq, 32'h9000_0000, 1'b1);
    #1;
    chk("unm_err1_hready", 64'(HREADY), 64'd0);
    chk("unm_err1_hresp", 64'(HRESP), 64'd1);
    tick();
    bus(HtransIdle, 32'h8000_0000, 1'b0);
    #1;
    chk("unm_err2_hready", 64'(HREADY), 64'd1);
    chk("unm_err2_hresp", 64'(HRESP), 64'd1);
    chk("unm_err_valid", 64'(ERR_VALID), 64'd1);
    chk("unm_err_addr", 64'(ERR_ADDR), 64'h8000_0000);
    chk("unm_err_src", 64'(ERR_SRC), 64'd3);
    tick();
    #1;
    chk("unm_after_hready", 64'(HREADY), 64'd1);
    chk("unm_after_hresp", 64'(HRESP), 64'd0);

    // Back-to-back unmapped transfers chain ERR1/ERR2 twice
    bus(HtransNonseq, 32'hA000_0000, 1'b0);
    tick();
    #1;
    chk("b2b_err1a_hready", 64'(HREADY), 64'd0);
    chk("b2b_err1a_hresp", 64'(HRESP), 64'd1);
    tick();
    bus(HtransNonseq, 32'hB000_0000, 1'b0);
    #1;
    chk("b2b_err2a_hready", 64'(HREADY), 64'd1);
    chk("b2b_err2a_hresp", 64'(HRESP), 64'd1);
    tick();
    #1;
    chk("b2b_err1b_hready", 64'(HREADY), 64'd0);
    chk("b2b_err1b_hresp", 64'(HRESP), 64'd1);
    tick();
    bus(HtransIdle, 32'h8000_0000, 1'b0);
    #1;
    chk("b2b_err2b_hready", 64'(HREADY), 64'd1);
    chk("b2b_err2b_hresp", 64'(HRESP), 64'd1);
    tick();
    #1;
    chk("b2b_idle_hresp", 64'(HRESP), 64'd0);
    chk("b2b_err_addr", 64'(ERR_ADDR), 64'h8000_0000);
    chk("b2b_err_src", 64'(ERR_SRC), 64'd3);

    // Clear, then slave 2 two-cycle ERROR
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    #1;
    chk("clr_err_valid", 64'(ERR_VALID), 64'd0);
    bus(HtransNonseq, 32'h2000_0010, 1'b0);
    #1;
    chk("s2_hsel", 64'(HSEL), 64'b100);
    tick();
    bus(HtransIdle, 32'h8000_0000, 1'b0);
    S_HREADYOUT[2] = 1'b0;
    S_HRESP[2]     = 1'b1;
    #1;
    chk("s2_err1_hready", 64'(HREADY), 64'd0);
    chk("s2_err1_hresp", 64'(HRESP), 64'd1);
    tick();
    S_HREADYOUT[2] = 1'b1;
    #1;
    chk("s2_err2_hready", 64'(HREADY), 64'd1);
    chk("s2_err_valid", 64'(ERR_VALID), 64'd1);
    chk("s2_err_src", 64'(ERR_SRC), 64'd2);
    chk("s2_err_addr", 64'(ERR_ADDR), 64'h2000_0010);
    tick();
    S_HRESP[2] = 1'b0;
    #1;
    chk("s2_after_hresp", 64'(HRESP), 64'd0);

    // ERR_CLR coinciding with a new default-slave error
    bus(HtransNonseq, 32'hC000_0000, 1'b0);
    tick();
    bus(HtransIdle, 32'h8000_0000, 1'b0);
    ERR_CLR = 1'b1;
    #1;
    chk("clrev_err1_hready", 64'(HREADY), 64'd0);
    tick();
    ERR_CLR = 1'b0;
    #1;
    chk("clrev_err_valid", 64'(ERR_VALID), 64'd1);
    chk("clrev_err_src", 64'(ERR_SRC), 64'd3);
    chk("clrev_err_addr", 64'(ERR_ADDR), 64'hC000_0000);
    tick();

    // Reset during a slave-0 wait state
    bus(HtransNonseq, 32'h0000_0100, 1'b0);
    #1;
    chk("s0_hsel", 64'(HSEL), 64'b001);
    tick();
    bus(HtransIdle, 32'h8000_0000, 1'b0);
    S_HREADYOUT[0] = 1'b0;
    #1;
    chk("s0_wait_hready", 64'(HREADY), 64'd0);
    chk("s0_wait_hrdata", 64'(HRDATA), 64'hA0A0_0000);
    HRESET = 1'b1;
    tick();
    #1;
    chk("mrst_hready", 64'(HREADY), 64'd1);
    chk("mrst_hresp", 64'(HRESP), 64'd0);
    chk("mrst_hrdata", 64'(HRDATA), 64'd0);
    chk("mrst_err_valid", 64'(ERR_VALID), 64'd0);
    HRESET = 1'b0;
    S_HREADYOUT[0] = 1'b1;

    // Default slave must be idle after reset: unmapped IDLE gives OKAY
    tick();
    #1;
    chk("mrst_fsm_idle_hresp", 64'(HRESP), 64'd0);
    chk("mrst_fsm_idle_hready", 64'(HREADY), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    failed++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_lite_interconnect.md
Name: ahb_lite_interconnect

Overview:
- Parametrised single-master AHB-Lite interconnect. Replaces the fixed 3-slave bus with a generic decoder, data-phase response mux and built-in default slave.
- Sits between one AHB-Lite master and NUM_S slaves.
- Adds a configurable address map, two-cycle ERROR response for unmapped accesses, and a sticky error-capture register for debug/interrupt use.

Parameters:
- NUM_S, 3, number of slaves (1..16)
- AW, 32, address width
- DW, 32, data width
- BASE_ADDR, {NUM_S{AW'h0}}, flat NUM_S*AW vector; slice i = base of slave i
- ADDR_MASK, {NUM_S{AW'h0}}, flat NUM_S*AW vector; slice i = compare mask of slave i

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- M_HADDR  in  AW  master address
- M_HTRANS  in  2  master transfer type
- M_HWRITE/M_HSIZE/M_HBURST/M_HPROT/M_HMASTLOCK  in  1/3/3/4/1  master control
- M_HWDATA  in  DW  master write data
- HSEL  out  NUM_S  one-hot slave select (address phase)
- HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HWDATA  out  as master  broadcast to slaves
- S_HRDATA  in  NUM_S*DW  slave read data, slice i
- S_HREADYOUT  in  NUM_S  slave ready
- S_HRESP  in  NUM_S  slave response
- HRDATA  out  DW  muxed read data to master
- HREADY  out  1  muxed ready, also fed back to slaves as HREADYin
- HRESP  out  1  muxed response
- ERR_CLR  in  1  clears error capture
- ERR_VALID  out  1  sticky error flag
- ERR_ADDR  out  AW  address of first captured error
- ERR_SRC  out  clog2(NUM_S+1)  source index; NUM_S = default slave

Behaviour:
- Reset (HRESET=1 at HCLK edge): data-phase select = NONE, FSM = IDLE, ERR_VALID=0, ERR_ADDR=0, ERR_SRC=0.
- Outputs during and after reset until the first accepted transfer: HREADY=1, HRESP=0, HRDATA=0.
- Broadcast signals: combinational pass-through, zero latency.
- Decode (combinational): match_i = ((M_HADDR & MASK_i) == (BASE_i & MASK_i)). Lowest index wins on overlap. HSEL = one-hot winner, driven regardless of HTRANS. No match → HSEL=0.
- Data-phase register: updated only on cycles with HREADY=1.
  - Captures winner index, or DEF if no match and M_HTRANS[1]=1, or NONE if no match and IDLE/BUSY.
  - Also captures M_HADDR into dp_addr.
- Response mux by data-phase select:
  - slave i → S_HRDATA[i], S_HREADYOUT[i], S_HRESP[i]
  - NONE → 1/0/0
  - DEF → FSM outputs, HRDATA=0
- Default-slave FSM (states IDLE, ERR1, ERR2):
  - IDLE→ERR1 when HREADY=1 and unmapped NONSEQ/SEQ.
  - ERR1: HREADY=0, HRESP=1; always →ERR2.
  - ERR2: HREADY=1, HRESP=1. →ERR1 if another unmapped active transfer is sampled this cycle, else →IDLE.
  - Unmapped IDLE/BUSY: OKAY, zero wait.
- Error capture:
  - Event = FSM entering ERR1 (src NUM_S), or selected slave i presenting HRESP=1 with HREADY=0 (src i).
  - Captured only when ERR_VALID=0; first error wins. ERR_ADDR = dp_addr.
  - ERR_CLR with a simultaneous event: event captured, ERR_VALID stays 1.
- Master changing HTRANS during ERR1 is ignored; sampling occurs only when HREADY=1.
- Reset mid-transfer aborts: select returns to NONE, FSM to IDLE next edge.

Decomposition:
- Package ahb_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP OKAY/ERROR, HSIZE/HBURST constants, default-slave FSM state encoding.
- One sub-module: ahb_default_slave (FSM and its ready/resp outputs).
- Decoder and mux are generate loops in the top.

Test Plan:
- NUM_S=3, BASE={0x0000_0000, 0x1000_0000, 0x2000_0000}, MASK=0xF000_0000. NONSEQ read 0x1000_0040 → HSEL=3'b010; next cycle HRDATA=S_HRDATA[1], HREADY follows S_HREADYOUT[1], including 2 wait states.
- NONSEQ write to 0x8000_0000 → HSEL=0. Next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1. ERR_VALID=1, ERR_ADDR=0x8000_0000, ERR_SRC=3.
- IDLE transfer to 0x8000_0000 → HREADY=1, HRESP=0 next cycle; ERR_VALID unchanged.
- Back-to-back unmapped NONSEQ accepted in ERR2 → ERR1, ERR2, ERR1, ERR2 with no IDLE gap. ERR_ADDR keeps the first address.
- Slave 2 returns two-cycle ERROR while ERR_VALID=0 → ERR_SRC=2. ERR_CLR in the same cycle as a new default-slave error → ERR_VALID=1, ERR_SRC=3.
- Assert HRESET during slave-0 wait state → next edge HREADY=1, HRESP=0, ERR_VALID=0, FSM IDLE.
